mem_store_buffer: RTL

//  Write side of the data SRAM port: buffers committed stores from the MEM stage in a small FIFO
//  and drains them to the data SRAM whenever the port is not used by an EX-stage load.

---
 rtl/mem_store_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - store buffer draining committed stores to the data SRAM port
// Optional feature macro STORE_MERGE_EN: same-word stores coalesce into the tail entry.
module mem_store_buffer #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [3:0]  st_wen,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_wdata,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   output logic        ld_stall,
   output logic        buf_empty,
   output logic        data_sram_en,
   output logic [3:0]  data_sram_wen,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] ONE_CNT  = (DEPTH_LOG2+1)'(1);

   logic [29:0]           addr_q  [DEPTH];
   logic [3:0]            wen_q   [DEPTH];
   logic [31:0]           wdata_q [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [DEPTH_LOG2-1:0] offs;
   logic                  full, accept, alloc, drain, hit, match, merge;
   logic                  unused_ok;

   assign unused_ok = ^{st_addr[1:0], ld_addr[1:0]};
   assign full      = (count_q == FULL_CNT);
   assign accept    = st_valid && !full;
   assign st_ready  = !rst && !full;
   assign buf_empty = !rst && (count_q == '0);

   // An entry is live when its distance from the head is below count.
   always_comb begin
      hit  = 1'b0;
      offs = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = DEPTH_LOG2'(i) - rd_ptr_q;
         if ({1'b0, offs} < count_q && addr_q[i] == ld_addr[31:2])
            hit = 1'b1;
      end
   end

   assign match = ld_en && (hit || (accept && st_addr[31:2] == ld_addr[31:2]));

   always_comb begin
      drain           = 1'b0;
      ld_stall        = 1'b0;
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'h0;
      data_sram_addr  = 32'h0;
      data_sram_wdata = 32'h0;
      if (full) begin
         ld_stall = ld_en;
         drain    = 1'b1;
      end else if (match) begin
         ld_stall = 1'b1;
         drain    = (count_q != '0);
      end else if (ld_en) begin
         data_sram_en   = 1'b1;
         data_sram_addr = {ld_addr[31:2], 2'b00};
      end else if (count_q != '0) begin
         drain = 1'b1;
      end
      if (drain) begin
         data_sram_en    = 1'b1;
         data_sram_wen   = wen_q[rd_ptr_q];
         data_sram_addr  = {addr_q[rd_ptr_q], 2'b00};
         data_sram_wdata = wdata_q[rd_ptr_q];
      end
      if (rst) begin
         drain           = 1'b0;
         ld_stall        = 1'b0;
         data_sram_en    = 1'b0;
         data_sram_wen   = 4'h0;
         data_sram_addr  = 32'h0;
         data_sram_wdata = 32'h0;
      end
   end

`ifdef STORE_MERGE_EN
   logic [DEPTH_LOG2-1:0] tail_ptr;
   assign tail_ptr = wr_ptr_q - DEPTH_LOG2'(1);
   // With one entry the tail is the head, so merging is only safe when it is not leaving.
   assign merge = accept && addr_q[tail_ptr] == st_addr[31:2] &&
                  (count_q > ONE_CNT || (count_q == ONE_CNT && !drain));
`else
   assign merge = 1'b0;
`endif
   assign alloc = accept && !merge;

   assign rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(drain);
   assign wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(alloc);
   assign count_d  = count_q + (DEPTH_LOG2+1)'(alloc) - (DEPTH_LOG2+1)'(drain);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc) begin
         addr_q[wr_ptr_q]  <= st_addr[31:2];
         wen_q[wr_ptr_q]   <= st_wen;
         wdata_q[wr_ptr_q] <= st_wdata;
      end
`ifdef STORE_MERGE_EN
      if (merge) begin
         wen_q[tail_ptr] <= wen_q[tail_ptr] | st_wen;
         for (int b = 0; b < 4; b++)
            if (st_wen[b])
               wdata_q[tail_ptr][8*b +: 8] <= st_wdata[8*b +: 8];
      end
`endif
   end
endmodule
